img_loader: RTL and testbench

//   Frame source directly upstream of the CNN top: ready/iaddr/idata side.

---
 rtl/img_loader.sv | 195 +++++++++++++++++++
 tb/tb_img_loader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/img_loader.sv
// img_loader: loads one 64x64 frame from a valid/ready host stream into frame RAM and serves iaddr->idata reads to the accelerator.
// Optional feature macro LOADER_CHECKSUM_EN adds chk_sum, the mod-2^24 sum of the words of the current frame.
module img_loader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 20,
  parameter int NPIX   = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              ready,
  input  logic              busy,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] idata,
  output logic              done,
  output logic [7:0]        frame_cnt,
`ifdef LOADER_CHECKSUM_EN
  output logic [23:0]       chk_sum,
`endif
  output logic              err
);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_ARM   = 2'd1,
    ST_SERVE = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] wr_ptr;
  logic              accept;
  logic              last_word;
  logic              s_ready_nxt;
  logic              ready_nxt;
  logic              done_nxt;
  logic              cnt_inc;
  logic              err_set;
  logic              rd_en;

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  // s_ready is only ever high in LOAD, so the handshake alone qualifies a write
  assign accept    = s_valid && s_ready;
  assign last_word = (wr_ptr == LAST_ADDR);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_LOAD;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_LOAD: begin
        if (accept && last_word) begin
          next_state = ST_ARM;
        end else begin
          next_state = ST_LOAD;
        end
      end
      ST_ARM: begin
        if (busy) begin
          next_state = ST_SERVE;
        end else begin
          next_state = ST_ARM;
        end
      end
      ST_SERVE: begin
        if (!busy) begin
          next_state = ST_FIN;
        end else begin
          next_state = ST_SERVE;
        end
      end
      ST_FIN: begin
        next_state = ST_LOAD;
      end
      default: begin
        next_state = ST_LOAD;
      end
    endcase
  end

  // Output decode; handshake flags are derived from next_state so the registered copies line up with the state
  always_comb begin
    s_ready_nxt = 1'b0;
    ready_nxt   = 1'b0;
    done_nxt    = 1'b0;
    cnt_inc     = 1'b0;
    rd_en       = 1'b0;
    err_set     = 1'b0;
    case (next_state)
      ST_LOAD:  s_ready_nxt = 1'b1;
      ST_ARM:   ready_nxt   = 1'b1;
      ST_FIN: begin
        done_nxt = 1'b1;
        cnt_inc  = 1'b1;
      end
      ST_SERVE: s_ready_nxt = 1'b0;
      default:  s_ready_nxt = 1'b0;
    endcase
    case (state)
      ST_LOAD:  err_set = busy;
      ST_FIN:   err_set = busy;
      ST_SERVE: rd_en   = 1'b1;
      ST_ARM:   err_set = 1'b0;
      default:  err_set = 1'b0;
    endcase
  end

  // Registered handshake, status and counter outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_ready   <= 1'b0;
      ready     <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= 8'd0;
      err       <= 1'b0;
    end else begin
      s_ready <= s_ready_nxt;
      ready   <= ready_nxt;
      done    <= done_nxt;
      if (cnt_inc) begin
        frame_cnt <= frame_cnt + 8'd1;
      end else begin
        frame_cnt <= frame_cnt;
      end
      if (err_set) begin
        err <= 1'b1;
      end else begin
        err <= err;
      end
    end
  end

  // Write pointer: wraps to 0 on the last word so the next frame starts at address 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= {ADDR_W{1'b0}};
    end else if (accept) begin
      if (last_word) begin
        wr_ptr <= {ADDR_W{1'b0}};
      end else begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
    end else begin
      wr_ptr <= wr_ptr;
    end
  end

  // Frame RAM write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= s_data;
    end
  end

  // Frame RAM read port: one-cycle latency, holds last value outside SERVE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idata <= {DATA_W{1'b0}};
    end else if (rd_en) begin
      idata <= mem[iaddr];
    end else begin
      idata <= idata;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running frame checksum: cleared on the way back into LOAD, frozen outside LOAD
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chk_sum <= 24'd0;
    end else if (state == ST_FIN) begin
      chk_sum <= 24'd0;
    end else if (accept) begin
      chk_sum <= chk_sum + 24'(s_data);
    end else begin
      chk_sum <= chk_sum;
    end
  end
`endif

endmodule

// File: tb/tb_img_loader.sv
// Self-checking bench for img_loader: randomized streams checked against an array/queue frame model.
`timescale 1ns/1ps
module tb_img_loader;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 20;
  localparam int NPIX   = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              ready;
  logic              busy;
  logic [ADDR_W-1:0] iaddr;
  logic [DATA_W-1:0] idata;
  logic              done;
  logic [7:0]        frame_cnt;
  logic              err;
`ifdef LOADER_CHECKSUM_EN
  logic [23:0]       chk_sum;
  logic [23:0]       chk_sum2;
`endif

  // small second instance (4-word frames) used for the 256-frame counter wrap
  logic              s_valid2;
  logic              s_ready2;
  logic              ready2;
  logic              busy2;
  logic [DATA_W-1:0] idata2;
  logic              done2;
  logic [7:0]        frame_cnt2;
  logic              err2;

  img_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NPIX(NPIX)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata), .done(done),
    .frame_cnt(frame_cnt),
`ifdef LOADER_CHECKSUM_EN
    .chk_sum(chk_sum),
`endif
    .err(err)
  );

  img_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NPIX(4)) dut2 (
    .clk(clk), .reset(reset), .s_valid(s_valid2), .s_data(20'h00005), .s_ready(s_ready2),
    .ready(ready2), .busy(busy2), .iaddr(12'd0), .idata(idata2), .done(done2),
    .frame_cnt(frame_cnt2),
`ifdef LOADER_CHECKSUM_EN
    .chk_sum(chk_sum2),
`endif
    .err(err2)
  );

  int                errors = 0;
  int                checks = 0;
  logic [DATA_W-1:0] ref_mem [0:NPIX-1];
  logic [7:0]        exp_frames = 8'd0;
  logic [23:0]       exp_sum = 24'd0;

  function automatic logic [DATA_W-1:0] gen_word(input int mode, input int idx);
    case (mode)
      0:       return DATA_W'(idx);
      1:       return DATA_W'($urandom);
      default: return 20'hFFFFF;
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b0; s_valid = 1'b0; s_data = 20'd0; busy = 1'b0; iaddr = 12'd0;
    s_valid2 = 1'b0; busy2 = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got %b exp 0", s_ready); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ready); end
    checks++; if (idata !== 20'd0) begin errors++; $display("FAIL reset_idata got %h exp 0", idata); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL reset_frame_cnt got %0d exp 0", frame_cnt); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL release_s_ready got %b exp 1", s_ready); end
  endtask

  // streams up to 'limit' words; returns the number of cycles s_ready was seen high
  task automatic load_frame(input int mode, input int gap_pct, input int limit, output int high_cycles);
    int idx; int guard; logic took; logic [DATA_W-1:0] w;
    idx = 0; guard = 0; high_cycles = 0; exp_sum = 24'd0;
    w = gen_word(mode, 0);
    while (idx < limit && guard < 40000) begin
      s_valid = ($urandom_range(0, 99) >= gap_pct);
      s_data  = w;
      took    = s_valid && s_ready;
      if (s_ready) high_cycles++;
      @(posedge clk); @(negedge clk);
      guard++;
      if (took) begin
        ref_mem[idx] = w;
        exp_sum = exp_sum + 24'(w);
        idx++;
        w = gen_word(mode, idx);
      end
    end
    s_valid = 1'b0;
    checks++; if (idx !== limit) begin errors++; $display("FAIL load_words got %0d exp %0d", idx, limit); end
    if (limit == NPIX) begin
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL load_ready got %b exp 1", ready); end
      checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL load_s_ready_low got %b exp 0", s_ready); end
`ifdef LOADER_CHECKSUM_EN
      checks++; if (chk_sum !== exp_sum) begin errors++; $display("FAIL load_chk_sum got %h exp %h", chk_sum, exp_sum); end
`endif
    end
  endtask

  task automatic start_serve();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL arm_ready got %b exp 1", ready); end
    busy = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL serve_ready_drop got %b exp 0", ready); end
  endtask

  task automatic read_seq(input logic [ADDR_W-1:0] addrs[$]);
    foreach (addrs[i]) begin
      iaddr = addrs[i];
      @(posedge clk); @(negedge clk);
      checks++;
      if (idata !== ref_mem[addrs[i]]) begin
        errors++; $display("FAIL read addr %0d got %h exp %h", addrs[i], idata, ref_mem[addrs[i]]);
      end
    end
  endtask

  task automatic finish_frame();
    busy = 1'b0;
    @(posedge clk); @(negedge clk);
    exp_frames = exp_frames + 8'd1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL fin_done got %b exp 1", done); end
    checks++; if (frame_cnt !== exp_frames) begin errors++; $display("FAIL fin_frame_cnt got %0d exp %0d", frame_cnt, exp_frames); end
`ifdef LOADER_CHECKSUM_EN
    checks++; if (chk_sum !== exp_sum) begin errors++; $display("FAIL fin_chk_frozen got %h exp %h", chk_sum, exp_sum); end
`endif
    @(posedge clk); @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL fin_done_pulse got %b exp 0", done); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reload_s_ready got %b exp 1", s_ready); end
`ifdef LOADER_CHECKSUM_EN
    checks++; if (chk_sum !== 24'd0) begin errors++; $display("FAIL reload_chk_clear got %h exp 0", chk_sum); end
`endif
  endtask

  task automatic test_sequential_load();
    int hc; logic [ADDR_W-1:0] q[$];
    load_frame(0, 0, NPIX, hc);
    checks++; if (hc !== NPIX) begin errors++; $display("FAIL s_ready_cycles got %0d exp %0d", hc, NPIX); end
    start_serve();
    q = '{12'd0, 12'd1, 12'd4095, 12'd17};
    read_seq(q);
    finish_frame();
  endtask

  task automatic test_gapped_load();
    int hc; logic [ADDR_W-1:0] q[$];
    load_frame(1, 50, NPIX, hc);
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = DATA_W'($urandom);
      @(posedge clk); @(negedge clk);
      checks++; if (s_ready !== 1'b0 || ready !== 1'b1) begin
        errors++; $display("FAIL extra_pulse s_ready=%b ready=%b exp 0/1", s_ready, ready);
      end
    end
    s_valid = 1'b0;
    start_serve();
    q.push_back(12'd0);
    for (int i = 0; i < NPIX; i++) q.push_back(ADDR_W'($urandom_range(0, NPIX - 1)));
    read_seq(q);
    finish_frame();
  endtask

  task automatic test_err_and_midload_reset();
    int hc; logic [ADDR_W-1:0] q[$];
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", err); end
    busy = 1'b1;
    @(posedge clk); @(negedge clk);
    busy = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", err); end
    repeat (3) @(negedge clk);
    checks++; if (err !== 1'b1 || s_ready !== 1'b1) begin
      errors++; $display("FAIL err_sticky err=%b s_ready=%b exp 1/1", err, s_ready);
    end
    load_frame(1, 0, 100, hc);
    reset = 1'b0;
    #1;
    exp_frames = 8'd0;
    checks++; if (s_ready !== 1'b0 || ready !== 1'b0 || err !== 1'b0 || frame_cnt !== 8'd0 || idata !== 20'd0) begin
      errors++; $display("FAIL midload_reset s_ready=%b ready=%b err=%b cnt=%0d idata=%h exp all 0", s_ready, ready, err, frame_cnt, idata);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    load_frame(1, 20, NPIX, hc);
    start_serve();
    for (int i = 0; i < 128; i++) q.push_back(ADDR_W'(i));
    for (int i = 0; i < 64; i++) q.push_back(ADDR_W'($urandom_range(0, NPIX - 1)));
    read_seq(q);
    finish_frame();
  endtask

  task automatic test_checksum();
    int hc; logic [ADDR_W-1:0] q[$];
    load_frame(2, 10, NPIX, hc);
`ifdef LOADER_CHECKSUM_EN
    checks++; if (chk_sum !== 24'hFFF000) begin errors++; $display("FAIL chk_all_ones got %h exp fff000", chk_sum); end
`endif
    start_serve();
    q = '{12'd5, 12'd4095};
    read_seq(q);
    finish_frame();
  endtask

  task automatic test_frame_wrap();
    int acc; int guard; logic [7:0] exp2;
    exp2 = 8'd0;
    for (int f = 0; f < 256; f++) begin
      acc = 0; guard = 0;
      while (acc < 4 && guard < 50) begin
        s_valid2 = 1'b1;
        if (s_ready2) acc++;
        @(posedge clk); @(negedge clk);
        guard++;
      end
      s_valid2 = 1'b0;
      busy2 = 1'b1;
      @(posedge clk); @(negedge clk);
      busy2 = 1'b0;
      @(posedge clk); @(negedge clk);
      exp2 = exp2 + 8'd1;
      checks++; if (done2 !== 1'b1 || frame_cnt2 !== exp2) begin
        errors++; $display("FAIL wrap_frame %0d done=%b cnt=%0d exp 1/%0d", f, done2, frame_cnt2, exp2);
      end
    end
    checks++; if (frame_cnt2 !== 8'd0) begin errors++; $display("FAIL wrap_zero got %0d exp 0", frame_cnt2); end
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_sequential_load();
    test_gapped_load();
    test_err_and_midload_reset();
    test_checksum();
    test_frame_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
